counter_rate_ctrl: RTL

Rate controller for the LED counter on the Tang Nano 9k. It synchronises and debounces the two active-low board buttons and arbitrates their press events into a saturating speed exponent. It generates a one-cycle `tick` strobe at `WAIT_TIME >> rate_exp` cycles and drives the 6-bit active-low LED counter from that strobe. It replaces the free-running divide-based pacing with a shift-based, glitch-free scheduler.

---
 rtl/counter_rate_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/counter_rate_ctrl.sv
// Rate controller for the Tang Nano 9k LED counter.
// Two active-low buttons are synchronised and debounced, and their press
// events are arbitrated into a saturating speed exponent. A shift-derived
// period paces a one-cycle tick that advances a 6-bit active-low LED counter.
`timescale 1ns/1ps

module counter_rate_ctrl #(
    parameter int WAIT_TIME       = 13500000,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int MAX_EXP         = 6,
    parameter int CNT_W           = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn1,
    input  logic             btn2,
    output logic             tick,
    output logic [2:0]       rate_exp,
    output logic [CNT_W-1:0] period,
    output logic [5:0]       led
);

    localparam int               DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_VAL = CNT_W'(WAIT_TIME);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       MAX_VAL  = 3'(MAX_EXP);

    // Index 0 is button 1 ("faster"), index 1 is button 2 ("slower").
    logic [1:0] btn_raw;

    logic [1:0]            sync0_q, sync0_d;
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            deb_prev_q, deb_prev_d;
    logic [1:0]            press_q, press_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

    logic [2:0]       rate_exp_q, rate_exp_d;
    logic             rate_change;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [5:0]       led_cnt_q, led_cnt_d;

    assign btn_raw = {btn2, btn1};

    // Synchronise, debounce and turn each debounced falling edge into a one-cycle press.
    always_comb begin
        sync0_d    = btn_raw;
        sync1_d    = sync0_q;
        deb_d      = deb_q;
        db_cnt_d   = db_cnt_q;
        deb_prev_d = deb_q;
        press_d    = deb_prev_q & ~deb_q;
        for (int i = 0; i < 2; i++) begin
            if (sync1_q[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i] = '0;
                deb_d[i]    = sync1_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Arbitrate press events: chords reset the exponent, single presses step it with saturation.
    always_comb begin
        rate_exp_d = rate_exp_q;
        if (press_q[0] && (press_q[1] || !deb_q[1])) begin
            rate_exp_d = 3'd0;
        end else if (press_q[1] && !deb_q[0]) begin
            rate_exp_d = 3'd0;
        end else if (press_q[0]) begin
            if (rate_exp_q < MAX_VAL) begin
                rate_exp_d = rate_exp_q + 3'd1;
            end
        end else if (press_q[1]) begin
            if (rate_exp_q != 3'd0) begin
                rate_exp_d = rate_exp_q - 3'd1;
            end
        end
    end

    assign rate_change = (rate_exp_d != rate_exp_q);
    assign period      = WAIT_VAL >> rate_exp_q;

    // Pace the tick from the period; a real rate change restarts the phase and suppresses the tick.
    always_comb begin
        cnt_d     = cnt_q + CNT_ONE;
        tick_d    = 1'b0;
        led_cnt_d = led_cnt_q;
        if (rate_change) begin
            cnt_d = '0;
        end else if (cnt_q == period - CNT_ONE) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
        if (tick_q) begin
            led_cnt_d = led_cnt_q + 6'd1;
        end
    end

    // State registers; reset returns buttons to released and all counters to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q    <= 2'b11;
            sync1_q    <= 2'b11;
            deb_q      <= 2'b11;
            deb_prev_q <= 2'b11;
            press_q    <= 2'b00;
            db_cnt_q   <= '0;
            rate_exp_q <= 3'd0;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            led_cnt_q  <= 6'd0;
        end else begin
            sync0_q    <= sync0_d;
            sync1_q    <= sync1_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            press_q    <= press_d;
            db_cnt_q   <= db_cnt_d;
            rate_exp_q <= rate_exp_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            led_cnt_q  <= led_cnt_d;
        end
    end

    assign tick     = tick_q;
    assign rate_exp = rate_exp_q;
    assign led      = ~led_cnt_q;

endmodule
